// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared types and constants for the fetch path
package rv_core_pkg;

    localparam int XLEN = 32;
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        TRAP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_select.sv
// rtl/next_pc_select.sv - next-pc priority mux with alignment check
module next_pc_select
    import rv_core_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    // Jump beats branch beats fall-through; JAL/JALR targets lose bit 0.
    always_comb begin
        next_pc = pc + 32'd4;
        if (jump) begin
            next_pc = {jump_target[XLEN-1:1], 1'b0};
        end else if (pc_src) begin
            next_pc = branch_target;
        end
        misalign = |(next_pc[1:0] & INSTR_ALIGN_MASK);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction fetch sequencer
module pc_fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            advance,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned,
    output logic [XLEN-1:0] bad_addr,
    output logic [XLEN-1:0] instret
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] next_pc;
    logic            next_misalign;

    next_pc_select u_next_pc_select (
        .pc            (pc),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .next_pc       (next_pc),
        .misalign      (next_misalign)
    );

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // State register; reset restarts fetching at the reset vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state handshake outputs; ack only matters in FETCH.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        misaligned  = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (advance) begin
                    state_next = next_misalign ? TRAP : FETCH;
                end
            end
            TRAP: begin
                misaligned = 1'b1;
                state_next = FETCH;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // PC, captured instruction, trap address and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            instr    <= '0;
            bad_addr <= '0;
            instret  <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                    end
                end
                EXEC: begin
                    if (advance) begin
                        instret <= instret + 32'd1;
                        if (next_misalign) begin
                            bad_addr <= next_pc;
                            pc       <= TRAP_VECTOR;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int NSTEPS = 80;
    localparam int RST_STEP = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        advance = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic [31:0] bad_addr;
    logic [31:0] instret;

    pc_fetch_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .advance       (advance),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned),
        .bad_addr      (bad_addr),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] cnt;
    } exp_t;

    exp_t        addr_q[$];
    logic [31:0] trap_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= rst;

    // Instruction memory: variable wait states, spurious acks when idle.
    bit busy = 0;
    int wait_left = 0;
    int fetch_cnt = 0;
    always @(negedge clk) begin
        if (imem_req === 1'b1 && !rst_q) begin
            if (!busy) begin
                busy = 1;
                if (fetch_cnt < 4) wait_left = 0;
                else if (fetch_cnt % 4 == 3) wait_left = 5;
                else wait_left = $urandom_range(0, 3);
                fetch_cnt++;
            end
            if (wait_left == 0) begin
                imem_ack = 1'b1;
                imem_rdata = mem_fn(imem_addr);
                busy = 0;
            end else begin
                wait_left--;
                imem_ack = 1'b0;
                imem_rdata = $urandom;
            end
        end else begin
            busy = 0;
            imem_ack = (imem_req === 1'b0) && ($urandom_range(0, 5) == 0);
            imem_rdata = $urandom;
        end
    end

    // Monitor: pops expected fetches and traps as the DUT presents them.
    exp_t        cur;
    bit          have_cur = 0;
    logic        prev_req = 1'b0;
    logic        prev_mis = 1'b0;
    logic [31:0] exp_bad = '0;
    always @(negedge clk) begin
        if (rst_q) begin
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_pc", pc, RV);
            check("rst_instret", instret, 32'd0);
            check("rst_instr", instr, 32'd0);
            check("rst_bad_addr", bad_addr, 32'd0);
            check("rst_misaligned", 32'(misaligned), 32'd0);
            addr_q.delete();
            trap_q.delete();
            addr_q.push_back('{addr: RV, cnt: 32'd0});
            have_cur = 0;
            prev_req = 1'b0;
            prev_mis = 1'b0;
            exp_bad = '0;
        end else begin
            if (imem_req && !prev_req) begin
                if (addr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_fetch: got addr %h expected no fetch", imem_addr);
                end else begin
                    cur = addr_q.pop_front();
                    have_cur = 1;
                    check("fetch_addr", imem_addr, cur.addr);
                end
            end else if (imem_req && have_cur) begin
                check("fetch_pc_hold", pc, cur.addr);
                check("fetch_instret_hold", instret, cur.cnt);
            end
            if (instr_valid && have_cur) begin
                check("exec_pc", pc, cur.addr);
                check("exec_instr", instr, mem_fn(cur.addr));
                check("exec_pc_plus4", pc_plus4, cur.addr + 32'd4);
                check("exec_instret", instret, cur.cnt);
                check("exec_req", 32'(imem_req), 32'd0);
            end
            if (misaligned) begin
                check("trap_pulse_width", 32'(prev_mis), 32'd0);
                if (trap_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_trap: got bad_addr %h expected no trap", bad_addr);
                end else begin
                    exp_bad = trap_q.pop_front();
                end
                check("trap_req", 32'(imem_req), 32'd0);
                check("trap_instr_valid", 32'(instr_valid), 32'd0);
            end
            check("bad_addr", bad_addr, exp_bad);
            prev_req = imem_req;
            prev_mis = misaligned;
        end
    end

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          abort = 0;

    task automatic wait_exec();
        for (int k = 0; k < 200; k++) begin
            if (instr_valid === 1'b1) begin
                advance = 1'b0;
                jump = 1'b0;
                pc_src = 1'b0;
                return;
            end
            advance = 1'(($urandom_range(0, 1)));
            pc_src = 1'b1;
            jump = 1'(($urandom_range(0, 1)));
            branch_target = $urandom;
            jump_target = $urandom;
            @(negedge clk);
        end
        n_vec++;
        n_err++;
        $display("FAIL exec_timeout: got instr_valid %b expected 1 within 200 cycles", instr_valid);
        abort = 1;
    endtask

    task automatic pick(input int step);
        jump = 1'b0;
        pc_src = 1'b0;
        branch_target = $urandom;
        jump_target = $urandom;
        case (step)
            0, 1, 2, 3, 8: ;
            4: begin pc_src = 1'b1; branch_target = 32'h0000_0040; end
            5: begin pc_src = 1'b1; branch_target = 32'h0000_0044; jump = 1'b1; jump_target = 32'h0000_0081; end
            6: begin pc_src = 1'b1; branch_target = 32'h0000_0022; end
            7: begin jump = 1'b1; jump_target = 32'hFFFF_FFFC; end
            9: begin jump = 1'b1; jump_target = 32'h0000_0003; end
            default: begin
                jump = ($urandom_range(0, 3) == 0);
                pc_src = ($urandom_range(0, 2) == 0);
                branch_target = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & ~32'h3);
                jump_target = ($urandom_range(0, 4) == 0) ? $urandom
                                                          : (($urandom & ~32'h3) | 32'($urandom_range(0, 1)));
            end
        endcase
    endtask

    // Driver and reference model: issue one advance per EXEC, queue what must follow.
    initial begin
        logic [31:0] nxt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_pc = RV;
        m_cnt = 32'd0;
        for (int step = 0; step < NSTEPS && !abort; step++) begin
            wait_exec();
            if (abort) break;
            if (step == RST_STEP) begin
                rst = 1'b1;
                advance = 1'b1;
                pc_src = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                advance = 1'b0;
                pc_src = 1'b0;
                m_pc = RV;
                m_cnt = 32'd0;
                continue;
            end
            pick(step);
            if (jump) nxt = {jump_target[31:1], 1'b0};
            else if (pc_src) nxt = branch_target;
            else nxt = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
            if (nxt % 4 != 0) begin
                trap_q.push_back(nxt);
                m_pc = TV;
            end else begin
                m_pc = nxt;
            end
            addr_q.push_back('{addr: m_pc, cnt: m_cnt});
            advance = 1'b1;
            @(negedge clk);
            advance = 1'b0;
            jump = 1'b0;
            pc_src = 1'b0;
        end
        if (!abort) wait_exec();
        check("pending_fetches", 32'(addr_q.size()), 32'd0);
        check("pending_traps", 32'(trap_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Consumes the branch comparator's taken decision (pc_src) and the jump controls. Owns the program counter and sequences instruction fetch from instruction memory using a req/ack handshake. It presents each fetched instruction to the core and waits for the core's advance pulse before redirecting. Misaligned targets are trapped to a fixed vector.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
TRAP_VECTOR, 32'h0000_0100, PC loaded when a misaligned next-PC is detected.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
pc_src  in  1  branch taken from the comparator; sampled only in EXEC on advance.
branch_target  in  32  PC-relative branch target (pc + B-imm, computed upstream).
jump  in  1  JAL/JALR taken; sampled only in EXEC on advance.
jump_target  in  32  jump target; bit 0 forced to 0 internally.
advance  in  1  core finished the current instruction; one-cycle pulse.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address, always equal to pc.
imem_ack  in  1  instruction-memory response valid.
imem_rdata  in  32  instruction word, qualified by imem_ack.
instr  out  32  captured instruction.
instr_valid  out  1  instr is valid for execution.
pc  out  32  address of the current instruction.
pc_plus4  out  32  pc + 4, for link-register writeback.
misaligned  out  1  one-cycle pulse on trap redirect.
bad_addr  out  32  offending target; holds until the next trap.
instret  out  32  retired-instruction counter; wraps modulo 2^32.

Behaviour:
- Reset (rst=1 at an edge, takes priority over everything):
  - state=FETCH, pc=RESET_VECTOR.
  - instr=0, instr_valid=0, misaligned=0, bad_addr=0, instret=0.
  - imem_req=1 in the first cycle after rst deasserts.
  - Reset mid-fetch or mid-EXEC abandons the operation; no instret increment.
- States: FETCH, EXEC, TRAP.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ack: instr<=imem_rdata, go to EXEC. imem_req drops the cycle after ack.
  - Ack latency is unbounded; req stays high until ack.
- EXEC:
  - imem_req=0, instr_valid=1.
  - Without advance: hold indefinitely; pc and instr stay stable.
  - On advance, compute next as follows:
    - jump=1: next={jump_target[31:1],1'b0}. jump has priority over pc_src.
    - else pc_src=1: next=branch_target.
    - else: next=pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
  - instret increments on every advance in EXEC, including trapping ones.
  - If next[1:0]!=0: bad_addr<=next, pc<=TRAP_VECTOR, go to TRAP.
  - Else: pc<=next, go to FETCH.
- TRAP:
  - Lasts exactly one cycle: misaligned=1, instr_valid=0, imem_req=0.
  - Then goes to FETCH at TRAP_VECTOR.
- Signals ignored outside EXEC: advance, pc_src and jump. imem_ack is sampled only in FETCH; an ack seen in EXEC or TRAP is dropped.
- pc_plus4 is combinational pc+4 and wraps.
- Latency with zero-wait memory: advance to the next instr_valid is 2 cycles (FETCH 1 cycle, then EXEC). Through a trap it is 3 cycles.

Decomposition:
- Shared package rv_core_pkg holds:
  - state enum fetch_state_t {FETCH, EXEC, TRAP}.
  - constants XLEN=32 and INSTR_ALIGN_MASK=2'b11.
- One natural sub-module: next_pc_select, a pure combinational priority mux plus the misalign check.
- The FSM, PC register and counter remain in pc_fetch_unit.

Test Plan:
1. Reset then sequential fetch.
   - Stimulus: rst 2 cycles; zero-wait ack with rdata=32'h0000_0013; advance each EXEC, no branch.
   - Required: imem_addr = 0x0, 0x4, 0x8; instret = 3 after three advances.
2. Taken branch and jump priority.
   - Branch: pc=0x10, pc_src=1, branch_target=0x40, advance. Next imem_addr=0x40.
   - Jump priority: pc_src=1 and jump=1, jump_target=0x81. Next imem_addr=0x80.
3. Misaligned branch.
   - Stimulus: pc_src=1, branch_target=0x22, advance.
   - Required: misaligned pulses 1 cycle, bad_addr=0x22, next imem_addr=0x100, instret incremented.
4. Slow memory and spurious inputs.
   - Stimulus: ack delayed 5 cycles; pulse advance and pc_src=1 during FETCH.
   - Required: imem_req held 5 cycles, pc unchanged, instret unchanged, instr captured only on ack.
5. Reset in EXEC.
   - Stimulus: rst asserted with advance=1 and pc_src=1 in EXEC.
   - Required: pc=RESET_VECTOR, instret=0, instr_valid=0 next cycle.
6. Wrap-around.
   - Stimulus: pc=0xFFFF_FFFC, advance, no branch.
   - Required: next imem_addr=0x0; pc_plus4=0x0 while in EXEC at 0xFFFF_FFFC.
